// File: rtl/div_sequencer_if.sv
// Request/response bundle between the pipeline and the multi-cycle divider.
// Optional flush signal is present only when DIV_SEQUENCER_FLUSH_EN is defined.
interface div_sequencer_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
`ifdef DIV_SEQUENCER_FLUSH_EN
  logic            flush;

  modport master (
    output in_valid, control, op_a, op_b, out_ready, flush,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  in_valid, control, op_a, op_b, out_ready, flush,
    output in_ready, out_valid, result, busy
  );
`else
  modport master (
    output in_valid, control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  in_valid, control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
`endif
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divide/remainder unit (div/divu/rem/remu), one op at a time, XLEN+2 cycle latency.
// Optional DIV_SEQUENCER_FLUSH_EN adds a flush input that returns the FSM to IDLE.
module div_sequencer #(
  parameter  int XLEN  = 64,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [2:0]      state_q, state_d;
  logic [1:0]      ctrl_q,  ctrl_d;
  logic [XLEN-1:0] a_q,     a_d;
  logic [XLEN-1:0] b_q,     b_d;
  logic [XLEN-1:0] quo_q,   quo_d;
  logic [XLEN-1:0] rem_q,   rem_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic            qneg_q,  qneg_d;
  logic            rneg_q,  rneg_d;

  logic            is_signed;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  assign is_signed = ~ctrl_q[0];
  assign a_mag     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign b_mag     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

  // The partial remainder never reaches |b|, so only the trial value needs the extra bit.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, b_mag};

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ctrl_d  = bus.control;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Special results pass through FIX with sign correction suppressed.
        if (b_q == '0) begin
          quo_d   = ALL_ONES;
          rem_d   = a_q;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end else if (is_signed && (a_q == MIN_VAL) && (b_q == ALL_ONES)) begin
          quo_d   = MIN_VAL;
          rem_d   = '0;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end else begin
          quo_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg_d  = is_signed & a_q[XLEN-1];
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (qneg_q) begin
          quo_d = -quo_q;
        end
        if (rneg_q) begin
          rem_d = -rem_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef DIV_SEQUENCER_FLUSH_EN
    if (bus.flush) begin
      state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = ctrl_q[1] ? rem_q : quo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer at XLEN=64.
module tb_div_sequencer;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN_V = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(XLEN)) bus ();
  div_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Issues one op, returns its result and accept-to-out_valid latency (-1 on timeout), then completes the handshake.
  task automatic do_op(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    bus.control  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
    res = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.control = '0; bus.op_a = '0; bus.op_b = '0;
`ifdef DIV_SEQUENCER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    #12;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.result !== 64'd0) $display("FAIL reset_result got %h want 0", bus.result); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [63:0] r; int lat;
    do_op(2'b00, 64'd100, 64'd7, r, lat);
    n_checks++; if (r !== 64'd14) $display("FAIL div_100_7 got %0d want 14", r); else n_pass++;
    n_checks++; if (lat !== 66) $display("FAIL div_latency got %0d want 66", lat); else n_pass++;
    do_op(2'b10, 64'd100, 64'd7, r, lat);
    n_checks++; if (r !== 64'd2) $display("FAIL rem_100_7 got %0d want 2", r); else n_pass++;
    n_checks++; if (lat !== 66) $display("FAIL rem_latency got %0d want 66", lat); else n_pass++;
  endtask

  task automatic test_signed;
    logic [63:0] r; int lat;
    do_op(2'b00, -64'sd100, 64'd7, r, lat);
    n_checks++; if (r !== -64'sd14) $display("FAIL div_m100_7 got %h want %h", r, -64'sd14); else n_pass++;
    do_op(2'b10, -64'sd100, 64'd7, r, lat);
    n_checks++; if (r !== -64'sd2) $display("FAIL rem_m100_7 got %h want %h", r, -64'sd2); else n_pass++;
    do_op(2'b10, 64'd100, -64'sd7, r, lat);
    n_checks++; if (r !== 64'd2) $display("FAIL rem_100_m7 got %h want 2", r); else n_pass++;
    do_op(2'b01, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, lat);
    n_checks++; if (r !== 64'h2492_4924_9249_2484) $display("FAIL divu_big_7 got %h want 2492492492492484", r); else n_pass++;
    n_checks++; if (lat !== 66) $display("FAIL divu_latency got %0d want 66", lat); else n_pass++;
  endtask

  task automatic test_div_zero;
    logic [63:0] r, exp_r; int lat;
    for (int c = 0; c < 4; c++) begin
      exp_r = (c >= 2) ? 64'd123 : ONES;
      do_op(2'(c), 64'd123, 64'd0, r, lat);
      n_checks++; if (r !== exp_r) $display("FAIL divzero_ctrl%0d got %h want %h", c, r, exp_r); else n_pass++;
      n_checks++; if (lat !== 2) $display("FAIL divzero_latency_ctrl%0d got %0d want 2", c, lat); else n_pass++;
    end
  endtask

  task automatic test_overflow;
    logic [63:0] r; int lat;
    do_op(2'b00, MIN_V, ONES, r, lat);
    n_checks++; if (r !== MIN_V) $display("FAIL ovf_div got %h want %h", r, MIN_V); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL ovf_latency got %0d want 2", lat); else n_pass++;
    do_op(2'b10, MIN_V, ONES, r, lat);
    n_checks++; if (r !== 64'd0) $display("FAIL ovf_rem got %h want 0", r); else n_pass++;
    do_op(2'b01, MIN_V, ONES, r, lat);
    n_checks++; if (r !== 64'd0) $display("FAIL ovf_divu got %h want 0", r); else n_pass++;
    n_checks++; if (lat !== 66) $display("FAIL ovf_divu_latency got %0d want 66", lat); else n_pass++;
    do_op(2'b11, MIN_V, ONES, r, lat);
    n_checks++; if (r !== MIN_V) $display("FAIL ovf_remu got %h want %h", r, MIN_V); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [63:0] r; int lat;
    bus.control = 2'b00; bus.op_a = 64'd50; bus.op_b = 64'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_wait_done got %b want 1", bus.out_valid); else n_pass++;
    bus.control = 2'b01; bus.op_a = 64'd7; bus.op_b = 64'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc%0d got %b want 1", i, bus.out_valid); else n_pass++;
      n_checks++; if (bus.result !== 64'd10) $display("FAIL bp_hold_result cyc%0d got %0d want 10", i, bus.result); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc%0d got %b want 0", i, bus.in_ready); else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL bp_release_idle got %b want 0", bus.busy); else n_pass++;
    bus.in_valid = 1'b0;
    do_op(2'b10, 64'd50, 64'd7, r, lat);
    n_checks++; if (r !== 64'd1) $display("FAIL bp_next_op got %0d want 1", r); else n_pass++;
    n_checks++; if (lat !== 66) $display("FAIL bp_next_latency got %0d want 66", lat); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; int lat;
    bus.control = 2'b00; bus.op_a = 64'd1000; bus.op_b = 64'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.result !== 64'd0) $display("FAIL midrst_result got %h want 0", bus.result); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op(2'b00, 64'd81, 64'd9, r, lat);
    n_checks++; if (r !== 64'd9) $display("FAIL midrst_fresh got %0d want 9", r); else n_pass++;
    n_checks++; if (lat !== 66) $display("FAIL midrst_latency got %0d want 66", lat); else n_pass++;
  endtask

`ifdef DIV_SEQUENCER_FLUSH_EN
  task automatic test_flush;
    bit seen;
    bus.control = 2'b00; bus.op_a = 64'd500; bus.op_b = 64'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL flush_idle got %b want 0", bus.busy); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_valid got %b want 0", seen); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
`ifdef DIV_SEQUENCER_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
